// File: rtl/cl_serial_seq_pkg.sv
// Shared encodings for the bit-serial logic sequencer:
// cell op codes and controller states.
package cl_serial_seq_pkg;

   localparam logic [1:0] CL_AND  = 2'b00;
   localparam logic [1:0] CL_OR   = 2'b01;
   localparam logic [1:0] CL_XOR  = 2'b10;
   localparam logic [1:0] CL_NOTA = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/cl_serial_seq_cl.sv
// One-bit logic cell: the four candidate results feed
// a 4:1 mux steered by the op code.
module mux4_1 (
   input  logic [3:0] d,
   input  logic [1:0] sel,
   output logic       y
);

   assign y = d[sel];

endmodule

module cl
   import cl_serial_seq_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic [1:0] s,
   output logic       y
);

   logic [3:0] cand;

   // candidate slots follow the op code values
   always_comb begin
      cand          = '0;
      cand[CL_AND]  = a & b;
      cand[CL_OR]   = a | b;
      cand[CL_XOR]  = a ^ b;
      cand[CL_NOTA] = ~a;
   end

   mux4_1 u_mux (
      .d  (cand),
      .sel(s),
      .y  (y)
   );

endmodule

// File: rtl/cl_serial_seq.sv
// Bit-serial sequencer: streams N-bit operands LSB first
// through one cl cell and assembles the N-bit result.
module cl_serial_seq
   import cl_serial_seq_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [1:0]   s,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] out,
   output logic         z
);

   localparam int CW = $clog2(N);

   state_t          state;
   state_t          state_nx;
   logic [CW-1:0]   cnt;
   logic [N-1:0]    sa;
   logic [N-1:0]    sb;
   logic [N-1:0]    r;
   logic [N-1:0]    res;
   logic [1:0]      op;
   logic            clo;
   logic            last;

   cl u_cl (
      .a(sa[0]),
      .b(sb[0]),
      .s(op),
      .y(clo)
   );

   assign res  = {clo, r[N-1:1]};
   assign last = (cnt == CW'(N-1));
   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);

   // next-state decode; DONE always falls back to IDLE
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (start) state_nx = S_RUN;
         S_RUN:   if (last)  state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // operand capture, bit shifting and result commit
   always_ff @(posedge clk) begin
      if (reset) begin
         sa  <= '0;
         sb  <= '0;
         r   <= '0;
         op  <= CL_AND;
         cnt <= '0;
         out <= '0;
         z   <= 1'b1;
      end else if (state == S_IDLE) begin
         if (start) begin
            sa  <= a;
            sb  <= b;
            op  <= s;
            cnt <= '0;
         end
      end else if (state == S_RUN) begin
         sa  <= sa >> 1;
         sb  <= sb >> 1;
         r   <= res;
         cnt <= cnt + CW'(1);
         if (last) begin
            out <= res;
            z   <= (res == '0);
         end
      end
   end

endmodule

// File: tb/tb_cl_serial_seq.sv
// Directed bench for cl_serial_seq: N=8 and N=2
// instances, hand-computed results and timing.
module tb_cl_serial_seq;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic [1:0] s;
   logic       busy;
   logic       done;
   logic [7:0] out;
   logic       z;

   logic       start2;
   logic [1:0] a2;
   logic [1:0] b2;
   logic [1:0] s2;
   logic       busy2;
   logic       done2;
   logic [1:0] out2;
   logic       z2;

   int errs;
   int checks;

   cl_serial_seq #(.N(8)) dut (
      .clk  (clk),
      .reset(reset),
      .start(start),
      .a    (a),
      .b    (b),
      .s    (s),
      .busy (busy),
      .done (done),
      .out  (out),
      .z    (z)
   );

   cl_serial_seq #(.N(2)) dut2 (
      .clk  (clk),
      .reset(reset),
      .start(start2),
      .a    (a2),
      .b    (b2),
      .s    (s2),
      .busy (busy2),
      .done (done2),
      .out  (out2),
      .z    (z2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errs++;
         $display("FAIL rst_busy got=%b want=0", busy);
      end
      checks++;
      if (done !== 1'b0) begin
         errs++;
         $display("FAIL rst_done got=%b want=0", done);
      end
      checks++;
      if (out !== 8'h00) begin
         errs++;
         $display("FAIL rst_out got=%h want=00", out);
      end
      checks++;
      if (z !== 1'b1) begin
         errs++;
         $display("FAIL rst_z got=%b want=1", z);
      end
      reset = 1'b0;
   endtask

   task automatic run_op(
      input logic [7:0] ta,
      input logic [7:0] tb_,
      input logic [1:0] ts,
      input logic [7:0] eo,
      input logic       ez,
      input bit         scr,
      input string      nm
   );
      int k;
      bit got;
      a = ta;
      b = tb_;
      s = ts;
      start = 1'b1;
      k = 0;
      got = 1'b0;
      while (!got && k < 20) begin
         @(posedge clk);
         #1;
         k++;
         if (k == 1) begin
            start = 1'b0;
            if (scr) begin
               a = ~ta;
               b = 8'h5A;
               s = ts + 2'd1;
            end
         end
         if (done) got = 1'b1;
      end
      checks++;
      if (k !== 9) begin
         errs++;
         $display("FAIL %s_lat got=%0d want=9", nm, k);
      end
      checks++;
      if (out !== eo) begin
         errs++;
         $display("FAIL %s_out got=%h want=%h", nm, out, eo);
      end
      checks++;
      if (z !== ez) begin
         errs++;
         $display("FAIL %s_z got=%b want=%b", nm, z, ez);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_ops();
      run_op(8'hC5, 8'h3A, 2'b00, 8'h00, 1'b1, 1'b0, "and1");
      run_op(8'hC5, 8'h3A, 2'b01, 8'hFF, 1'b0, 1'b0, "or1");
      run_op(8'hC5, 8'h3A, 2'b10, 8'hFF, 1'b0, 1'b0, "xor1");
      run_op(8'hC5, 8'h3A, 2'b11, 8'h3A, 1'b0, 1'b0, "nota1");
   endtask

   task automatic test_capture();
      run_op(8'hF0, 8'h3C, 2'b00, 8'h30, 1'b0, 1'b1, "and2");
      run_op(8'hF0, 8'h3C, 2'b01, 8'hFC, 1'b0, 1'b1, "or2");
      run_op(8'hF0, 8'h3C, 2'b10, 8'hCC, 1'b0, 1'b1, "xor2");
   endtask

   task automatic test_ignore_start();
      int nd;
      nd = 0;
      a = 8'hF0;
      b = 8'h3C;
      s = 2'b11;
      start = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (done) nd++;
         if (k <= 8) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
               errs++;
               $display("FAIL ign_busy k=%0d got=%b%b want=10",
                        k, busy, done);
            end
            checks++;
            if (out !== 8'hCC) begin
               errs++;
               $display("FAIL ign_hold k=%0d got=%h want=cc",
                        k, out);
            end
         end
         if (k == 9) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b1) begin
               errs++;
               $display("FAIL ign_end got=%b%b want=01",
                        busy, done);
            end
            checks++;
            if (out !== 8'h0F) begin
               errs++;
               $display("FAIL ign_out got=%h want=0f", out);
            end
         end
         if (k == 1 || k == 4 || k == 10) start = 1'b0;
         if (k == 3 || k == 9) start = 1'b1;
      end
      checks++;
      if (nd !== 1) begin
         errs++;
         $display("FAIL ign_count got=%0d want=1", nd);
      end
   endtask

   task automatic test_reset_abort();
      int nd;
      nd = 0;
      a = 8'hC5;
      b = 8'h3A;
      s = 2'b01;
      start = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) start = 1'b0;
         if (k > 5 && done) nd++;
         if (k == 5) begin
            reset = 1'b0;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
               errs++;
               $display("FAIL abort_bd got=%b%b want=00",
                        busy, done);
            end
            checks++;
            if (out !== 8'h00 || z !== 1'b1) begin
               errs++;
               $display("FAIL abort_oz got=%h/%b want=00/1",
                        out, z);
            end
         end
         if (k == 4) reset = 1'b1;
      end
      checks++;
      if (nd !== 0) begin
         errs++;
         $display("FAIL abort_done got=%0d want=0", nd);
      end
   endtask

   task automatic test_back_to_back();
      int nd;
      int lastk;
      nd = 0;
      lastk = 0;
      a = 8'hC5;
      b = 8'h3A;
      s = 2'b10;
      start = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            nd++;
            checks++;
            if (out !== 8'hFF || z !== 1'b0) begin
               errs++;
               $display("FAIL b2b_out k=%0d got=%h want=ff",
                        k, out);
            end
            if (lastk != 0) begin
               checks++;
               if (k - lastk !== 10) begin
                  errs++;
                  $display("FAIL b2b_gap got=%0d want=10",
                           k - lastk);
               end
            end
            lastk = k;
         end
      end
      start = 1'b0;
      checks++;
      if (nd !== 3) begin
         errs++;
         $display("FAIL b2b_count got=%0d want=3", nd);
      end
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic test_n2();
      int k;
      k = 0;
      a2 = 2'b01;
      b2 = 2'b11;
      s2 = 2'b10;
      start2 = 1'b1;
      while (k < 10) begin
         @(posedge clk);
         #1;
         k++;
         start2 = 1'b0;
         if (done2) break;
      end
      checks++;
      if (k !== 3) begin
         errs++;
         $display("FAIL n2_lat got=%0d want=3", k);
      end
      checks++;
      if (out2 !== 2'b10 || z2 !== 1'b0) begin
         errs++;
         $display("FAIL n2_out got=%b/%b want=10/0", out2, z2);
      end
   endtask

   initial begin
      errs = 0;
      checks = 0;
      reset = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      s = '0;
      start2 = 1'b0;
      a2 = '0;
      b2 = '0;
      s2 = '0;
      test_reset();
      test_ops();
      test_capture();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      test_n2();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
